sort_4x8b_seq_ctrl: RTL and testbench

Sequential bitonic sorter for four 8-bit lanes, built around a single shared compare-exchange unit.
- Steps the six compare-exchanges of the 4-input bitonic network, one per clock.
- Uses a valid/ready handshake on both input and output.
- Area-reduced alternative to the fully combinational sorter, for the synthetic sort benchmark set.
- Also reports how many exchanges were taken.

---
 rtl/sort_4x8b_seq_ctrl_if.sv | 37 +++
 rtl/sort_4x8b_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sort_4x8b_seq_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/sort_4x8b_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sort_4x8b_seq_ctrl_if
// Description : Handshake and data bundle for the sequential 4-lane sorter.
//               master : word producer / result consumer side
//               slave  : the sorter itself
//   in_valid/in_ready/data_in   : input word handshake (lane i at DATA_W*i)
//   abort                       : cancel an in-flight sort
//   out_valid/out_ready/data_out: sorted result handshake
//   swap_cnt                    : exchanges taken for the current result
//   busy                        : sort in progress
// Revision    : 1.0 - initial release
// ============================================================================
interface sort_4x8b_seq_ctrl_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DATA_W-1:0]   data_in;
    logic                  abort;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DATA_W-1:0]   data_out;
    logic [2:0]            swap_cnt;
    logic                  busy;

    modport master (
        output in_valid, data_in, abort, out_ready,
        input  in_ready, out_valid, data_out, swap_cnt, busy
    );

    modport slave (
        input  in_valid, data_in, abort, out_ready,
        output in_ready, out_valid, data_out, swap_cnt, busy
    );
endinterface
`default_nettype wire

// File: rtl/sort_4x8b_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sort_4x8b_seq_ctrl
// Description : Sequential bitonic sorter for four DATA_W-bit lanes. One shared
//               compare-exchange unit walks the six steps of the 4-input
//               bitonic network, one step per clock, and counts the swaps.
// Ports       : clk   - clock, rising edge
//               rst_n - asynchronous active-low reset
//               bus   - sort_4x8b_seq_ctrl_if.slave (handshakes, data, status)
//                       The interface DATA_W must match this module's DATA_W.
// Revision    : 1.0 - initial release
// ============================================================================
module sort_4x8b_seq_ctrl #(
    parameter int DATA_W  = 8,
    parameter bit DESCEND = 1'b0    // 1: lane0 ends with the maximum
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    sort_4x8b_seq_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] c_LAST_STEP = 3'd5;

    state_t               state_q, state_d;
    logic [4*DATA_W-1:0]  word_q, word_d;
    logic [2:0]           step_q, step_d;
    logic [2:0]           swap_cnt_q, swap_cnt_d;
    logic                 out_valid_q, out_valid_d;

    logic [DATA_W-1:0]    w_lane   [4];
    logic [DATA_W-1:0]    w_lane_x [4];
    logic [4*DATA_W-1:0]  w_word_x;
    logic [1:0]           w_idx_a, w_idx_b;
    logic                 w_asc;
    logic                 w_lo_first;
    logic [DATA_W-1:0]    w_a, w_b;
    logic                 w_swap;
    logic                 w_in_ready;
    logic                 w_accept;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane
            assign w_lane[i] = word_q[DATA_W*i +: DATA_W];
            assign w_word_x[DATA_W*i +: DATA_W] = w_lane_x[i];
        end
    endgenerate

    // Network step table: lane pair and whether lane A should end <= lane B
    // in ascending mode. DESCEND flips every sense.
    always_comb begin
        w_idx_a = 2'd0;
        w_idx_b = 2'd1;
        w_asc   = 1'b1;
        case (step_q)
            3'd0: begin w_idx_a = 2'd0; w_idx_b = 2'd1; w_asc = 1'b1; end
            3'd1: begin w_idx_a = 2'd2; w_idx_b = 2'd3; w_asc = 1'b0; end
            3'd2: begin w_idx_a = 2'd0; w_idx_b = 2'd2; w_asc = 1'b1; end
            3'd3: begin w_idx_a = 2'd1; w_idx_b = 2'd3; w_asc = 1'b1; end
            3'd4: begin w_idx_a = 2'd0; w_idx_b = 2'd1; w_asc = 1'b1; end
            3'd5: begin w_idx_a = 2'd2; w_idx_b = 2'd3; w_asc = 1'b1; end
            default: begin w_idx_a = 2'd0; w_idx_b = 2'd1; w_asc = 1'b1; end
        endcase
    end

    // Single shared comparator; strict compare so equal lanes never swap.
    always_comb begin
        w_lo_first = w_asc ^ DESCEND;
        w_a        = w_lane[w_idx_a];
        w_b        = w_lane[w_idx_b];
        w_swap     = w_lo_first ? (w_a > w_b) : (w_b > w_a);
        for (int k = 0; k < 4; k++) begin
            w_lane_x[k] = w_lane[k];
        end
        w_lane_x[w_idx_a] = w_b;
        w_lane_x[w_idx_b] = w_a;
    end

    assign w_in_ready = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        step_d      = step_q;
        swap_cnt_d  = swap_cnt_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    word_d      = bus.data_in;
                    step_d      = 3'd0;
                    swap_cnt_d  = 3'd0;
                    state_d     = SORT;
                end
            end
            SORT: begin
                if (bus.abort) begin
                    state_d    = IDLE;
                    step_d     = 3'd0;
                    swap_cnt_d = 3'd0;
                end else begin
                    if (w_swap) begin
                        word_d     = w_word_x;
                        swap_cnt_d = swap_cnt_q + 3'd1;
                    end
                    if (step_q == c_LAST_STEP) begin
                        state_d     = DONE;
                        step_d      = 3'd0;
                        out_valid_d = 1'b1;
                    end else begin
                        step_d = step_q + 3'd1;
                    end
                end
            end
            DONE: begin
                // in_ready is only high here when out_ready is, so an accept
                // always coincides with the result handshake.
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (bus.in_valid) begin
                        word_d     = bus.data_in;
                        step_d     = 3'd0;
                        swap_cnt_d = 3'd0;
                        state_d    = SORT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d     = IDLE;
                step_d      = 3'd0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            word_q      <= '0;
            step_q      <= 3'd0;
            swap_cnt_q  <= 3'd0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            step_q      <= step_d;
            swap_cnt_q  <= swap_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = word_q;
    assign bus.swap_cnt  = swap_cnt_q;
    assign bus.busy      = (state_q == SORT);

endmodule
`default_nettype wire

// File: tb/tb_sort_4x8b_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_4x8b_seq_ctrl
// Description : Directed bench for the sequential 4-lane sorter, covering
//               ascending and descending instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_4x8b_seq_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    sort_4x8b_seq_ctrl_if #(.DATA_W(8)) bus0 ();
    sort_4x8b_seq_ctrl_if #(.DATA_W(8)) bus1 ();

    sort_4x8b_seq_ctrl #(.DATA_W(8), .DESCEND(1'b0)) u_dut_asc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0.slave)
    );

    sort_4x8b_seq_ctrl #(.DATA_W(8), .DESCEND(1'b1)) u_dut_desc (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a word on the ascending DUT and hold it until accepted (<=20 edges).
    task automatic accept0(input logic [31:0] d);
        int n;
        n = 0;
        bus0.in_valid = 1'b1;
        bus0.data_in  = d;
        #0;
        while (!bus0.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
    endtask

    // Count edges until out_valid on the ascending DUT, bounded.
    task automatic wait_valid0(output int n);
        n = 0;
        while (!bus0.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
    endtask

    task automatic consume0();
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++; if (bus0.data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data_out got=%h exp=%h", bus0.data_out, 32'h0); end
        n_checks++; if (bus0.swap_cnt !== 3'd0) begin n_fail++; $display("FAIL reset_swap_cnt got=%0d exp=0", bus0.swap_cnt); end
        n_checks++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus0.out_valid); end
        n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus0.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", bus0.in_ready); end
        n_checks++; if (bus1.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_desc got=%b exp=1", bus1.in_ready); end
    endtask

    task automatic test_reverse();
        int n;
        accept0(32'h01020304);
        n_checks++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL rev_busy got=%b exp=1", bus0.busy); end
        // New word offered during SORT must be refused and not captured.
        bus0.in_valid = 1'b1;
        bus0.data_in  = 32'hDEADBEEF;
        #1;
        n_checks++; if (bus0.in_ready !== 1'b0) begin n_fail++; $display("FAIL rev_in_ready_sort got=%b exp=0", bus0.in_ready); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        wait_valid0(n);
        n = n + 2;
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL rev_latency got=%0d exp=6 edges", n); end
        n_checks++; if (bus0.data_out !== 32'h04030201) begin n_fail++; $display("FAIL rev_data got=%h exp=%h", bus0.data_out, 32'h04030201); end
        n_checks++; if (bus0.swap_cnt !== 3'd4) begin n_fail++; $display("FAIL rev_swap_cnt got=%0d exp=4", bus0.swap_cnt); end
        n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL rev_busy_done got=%b exp=0", bus0.busy); end
        consume0();
        n_checks++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL rev_out_valid_drop got=%b exp=0", bus0.out_valid); end
        n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL rev_in_ready_idle got=%b exp=1", bus0.in_ready); end
    endtask

    task automatic test_sorted_and_equal();
        int n;
        accept0(32'h04030201);
        wait_valid0(n);
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL sorted_latency got=%0d exp=6", n); end
        n_checks++; if (bus0.data_out !== 32'h04030201) begin n_fail++; $display("FAIL sorted_data got=%h exp=%h", bus0.data_out, 32'h04030201); end
        n_checks++; if (bus0.swap_cnt !== 3'd2) begin n_fail++; $display("FAIL sorted_swap_cnt got=%0d exp=2", bus0.swap_cnt); end
        consume0();
        accept0(32'h55555555);
        wait_valid0(n);
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL equal_latency got=%0d exp=6", n); end
        n_checks++; if (bus0.data_out !== 32'h55555555) begin n_fail++; $display("FAIL equal_data got=%h exp=%h", bus0.data_out, 32'h55555555); end
        n_checks++; if (bus0.swap_cnt !== 3'd0) begin n_fail++; $display("FAIL equal_swap_cnt got=%0d exp=0", bus0.swap_cnt); end
        consume0();
    endtask

    task automatic test_back_to_back();
        int n;
        accept0(32'h01020304);
        wait_valid0(n);
        for (int c = 0; c < 10; c++) begin
            n_checks++; if (bus0.data_out !== 32'h04030201 || bus0.swap_cnt !== 3'd4 || bus0.out_valid !== 1'b1 || bus0.in_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold_cycle%0d data=%h cnt=%0d ov=%b ir=%b exp data=04030201 cnt=4 ov=1 ir=0", c, bus0.data_out, bus0.swap_cnt, bus0.out_valid, bus0.in_ready);
            end
            @(posedge clk); #1;
        end
        bus0.out_ready = 1'b1;
        bus0.in_valid  = 1'b1;
        bus0.data_in   = 32'hFF00AA11;
        #1;
        n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready got=%b exp=1", bus0.in_ready); end
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        bus0.in_valid  = 1'b0;
        n_checks++; if (bus0.out_valid !== 1'b0 || bus0.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_handoff ov=%b busy=%b exp ov=0 busy=1", bus0.out_valid, bus0.busy); end
        wait_valid0(n);
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=6", n); end
        n_checks++; if (bus0.data_out !== 32'hFFAA1100) begin n_fail++; $display("FAIL b2b_data got=%h exp=%h", bus0.data_out, 32'hFFAA1100); end
        n_checks++; if (bus0.swap_cnt !== 3'd4) begin n_fail++; $display("FAIL b2b_swap_cnt got=%0d exp=4", bus0.swap_cnt); end
        consume0();
    endtask

    task automatic test_abort();
        accept0(32'h01020304);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus0.abort = 1'b1;
        @(posedge clk); #1;
        bus0.abort = 1'b0;
        n_checks++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", bus0.busy); end
        n_checks++; if (bus0.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_in_ready got=%b exp=1", bus0.in_ready); end
        n_checks++; if (bus0.swap_cnt !== 3'd0) begin n_fail++; $display("FAIL abort_swap_cnt got=%0d exp=0", bus0.swap_cnt); end
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            n_checks++; if (bus0.out_valid !== 1'b0) begin n_fail++; $display("FAIL abort_out_valid cycle%0d got=%b exp=0", c, bus0.out_valid); end
        end
    endtask

    task automatic test_reset_mid_sort();
        accept0(32'h01020304);
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus0.busy !== 1'b0 || bus0.swap_cnt !== 3'd0 || bus0.out_valid !== 1'b0 || bus0.data_out !== 32'h0) begin
            n_fail++; $display("FAIL midrst_outputs busy=%b cnt=%0d ov=%b data=%h exp busy=0 cnt=0 ov=0 data=00000000", bus0.busy, bus0.swap_cnt, bus0.out_valid, bus0.data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus0.in_ready !== 1'b1 || bus0.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_release ir=%b busy=%b exp ir=1 busy=0", bus0.in_ready, bus0.busy); end
    endtask

    task automatic test_descend();
        int n;
        bus1.in_valid = 1'b1;
        bus1.data_in  = 32'h01020304;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        n = 0;
        while (!bus1.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        n_checks++; if (n !== 6) begin n_fail++; $display("FAIL desc_latency got=%0d exp=6", n); end
        n_checks++; if (bus1.data_out !== 32'h01020304) begin n_fail++; $display("FAIL desc_data got=%h exp=%h", bus1.data_out, 32'h01020304); end
        n_checks++; if (bus1.swap_cnt !== 3'd2) begin n_fail++; $display("FAIL desc_swap_cnt got=%0d exp=2", bus1.swap_cnt); end
        bus1.in_valid  = 1'b1;
        bus1.data_in   = 32'hFF00AA11;
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid  = 1'b0;
        bus1.out_ready = 1'b0;
        n = 0;
        while (!bus1.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        n_checks++; if (bus1.data_out !== 32'h0011AAFF) begin n_fail++; $display("FAIL desc_data2 got=%h exp=%h", bus1.data_out, 32'h0011AAFF); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus0.in_valid = 1'b0; bus0.data_in = '0; bus0.abort = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.data_in = '0; bus1.abort = 1'b0; bus1.out_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        test_reset();
        test_reverse();
        test_sorted_and_equal();
        test_back_to_back();
        test_abort();
        test_reset_mid_sort();
        test_descend();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
